// File: rtl/wb_byte_master.sv
// Wishbone classic single-cycle initiator driven by a byte-stream host.
// Commands: 'W' adr[4] dat[4] / 'R' adr[4]; reply status byte (+ read data).
module wb_byte_master #(
  parameter int unsigned timeout_cycles = 1023,
  parameter logic [3:0]  sel_default    = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_STAT,
    S_RDAT
  } state_t;

  localparam logic [7:0]  CMD_W    = 8'h57;
  localparam logic [7:0]  CMD_R    = 8'h52;
  localparam logic [7:0]  ST_ACK   = 8'h06;
  localparam logic [7:0]  ST_ERR   = 8'h15;
  localparam logic [7:0]  ST_TMO   = 8'h14;
  localparam logic [7:0]  ST_BAD   = 8'h3F;
  localparam logic [31:0] TMO_LAST = 32'(timeout_cycles - 1);
  localparam logic        TMO_EN   = (timeout_cycles != 0);

  state_t      state, state_n;
  logic [1:0]  cnt;
  logic        is_wr, is_rd;
  logic [31:0] adr_q, dat_q, rdat_q, tmo_q;
  logic [7:0]  status_q, status_n;
  logic        cyc_q;
  logic        rx_fire, tx_fire, tmo_hit;

  assign rx_ready = (state == S_IDLE) || (state == S_ADDR) ||
                    (state == S_DATA);
  assign tx_valid = (state == S_STAT) || (state == S_RDAT);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign busy     = (state != S_IDLE);
  assign tmo_hit  = TMO_EN && (tmo_q == TMO_LAST);

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = cyc_q && is_wr;
  assign wb_sel_o = cyc_q ? sel_default : 4'h0;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

  // Reply byte: status first, then read data MSB first.
  always_comb begin
    tx_data = 8'h00;
    if (state == S_STAT)      tx_data = status_q;
    else if (state == S_RDAT) tx_data = rdat_q[31:24];
  end

  // Next state and status; bus termination priority ack > err/rty > timeout.
  always_comb begin
    state_n  = state;
    status_n = status_q;
    unique case (state)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_data == CMD_W || rx_data == CMD_R) begin
            state_n = S_ADDR;
          end else begin
            state_n  = S_STAT;
            status_n = ST_BAD;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire && cnt == 2'd3)
          state_n = is_wr ? S_DATA : S_BUS;
      end
      S_DATA: begin
        if (rx_fire && cnt == 2'd3)
          state_n = S_BUS;
      end
      S_BUS: begin
        if (wb_ack_i) begin
          state_n  = S_STAT;
          status_n = ST_ACK;
        end else if (wb_err_i || wb_rty_i) begin
          state_n  = S_STAT;
          status_n = ST_ERR;
        end else if (tmo_hit) begin
          state_n  = S_STAT;
          status_n = ST_TMO;
        end
      end
      S_STAT: begin
        if (tx_fire)
          state_n = (is_rd && status_q == ST_ACK) ? S_RDAT : S_IDLE;
      end
      S_RDAT: begin
        if (tx_fire && cnt == 2'd3)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, field shifters, timeout counter and registered cyc/stb.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      status_q <= 8'h00;
      cnt      <= 2'd0;
      is_wr    <= 1'b0;
      is_rd    <= 1'b0;
      adr_q    <= 32'h0;
      dat_q    <= 32'h0;
      rdat_q   <= 32'h0;
      tmo_q    <= 32'h0;
      cyc_q    <= 1'b0;
    end else begin
      state    <= state_n;
      status_q <= status_n;
      cyc_q    <= (state_n == S_BUS);
      if (state == S_IDLE && rx_fire) begin
        cnt   <= 2'd0;
        is_wr <= (rx_data == CMD_W);
        is_rd <= (rx_data == CMD_R);
      end
      if (state == S_ADDR && rx_fire) begin
        adr_q <= {adr_q[23:0], rx_data};
        cnt   <= cnt + 2'd1;
      end
      if (state == S_DATA && rx_fire) begin
        dat_q <= {dat_q[23:0], rx_data};
        cnt   <= cnt + 2'd1;
      end
      if (state == S_BUS) begin
        tmo_q <= tmo_q + 32'd1;
        if (wb_ack_i && is_rd)
          rdat_q <= wb_dat_i;
      end else begin
        tmo_q <= 32'h0;
      end
      if (state == S_RDAT && tx_fire) begin
        rdat_q <= {rdat_q[23:0], 8'h00};
        cnt    <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master: write, read, error, timeout,
// bad command, rx stalling during a bus cycle and mid-cycle reset.
module tb_wb_byte_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic        busy;

  always #5 clk = ~clk;

  wb_byte_master #(
    .timeout_cycles(8),
    .sel_default(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int hold_bad = 0;

  // slave behaviour: 0 ack, 1 err, 2 silent, 3 ack+err, 4 rty
  int          slv_mode = 0;
  int          slv_delay = 0;
  logic [31:0] slv_data = 32'h0;
  int          age = 0;
  logic        resp;

  assign wb_dat_i = slv_data;

  // Slave: respond once the strobe has been up for slv_delay cycles.
  always @(posedge clk) begin
    #2;
    if (wb_cyc_o && wb_stb_o) begin
      resp = (age == slv_delay);
      age++;
    end else begin
      resp = 1'b0;
      age = 0;
    end
    wb_ack_i = resp && (slv_mode == 0 || slv_mode == 3);
    wb_err_i = resp && (slv_mode == 1 || slv_mode == 3);
    wb_rty_i = resp && (slv_mode == 4);
  end

  int          cyc_cnt = 0;
  int          stb_cnt = 0;
  int          unstable = 0;
  int          stb_run = 0;
  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;

  // Bus monitor: counts cyc/stb cycles, captures and checks held fields.
  always @(negedge clk) begin
    if (wb_cyc_o) cyc_cnt++;
    if (wb_stb_o) begin
      if (stb_run == 0) begin
        cap_adr = wb_adr_o;
        cap_dat = wb_dat_o;
        cap_we  = wb_we_o;
        cap_sel = wb_sel_o;
      end else if (wb_adr_o !== cap_adr || wb_dat_o !== cap_dat ||
                   wb_we_o !== cap_we || wb_sel_o !== cap_sel) begin
        unstable++;
      end
      stb_run++;
      stb_cnt++;
    end else begin
      stb_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp,
                           input int stall);
    int n = 0;
    logic [7:0] d0;
    logic v0;
    while (!tx_valid && n < 200) begin
      tick();
      n++;
    end
    v0 = tx_valid;
    d0 = tx_data;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (!tx_valid || tx_data !== d0) hold_bad++;
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk({tag, "_valid"}, 32'(v0), 32'd1);
    chk(tag, 32'(d0), 32'(exp));
  endtask

  initial begin
    int c0, s0, u0;
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    #12;
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_cyc",      32'(wb_cyc_o), 32'd0);
    chk("rst_stb",      32'(wb_stb_o), 32'd0);
    chk("rst_we",       32'(wb_we_o),  32'd0);
    chk("rst_adr",      wb_adr_o,      32'd0);
    chk("rst_dat",      wb_dat_o,      32'd0);
    chk("rst_sel",      32'(wb_sel_o), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // write, ack in 3rd strobe cycle
    slv_mode = 0; slv_delay = 2;
    c0 = cyc_cnt; u0 = unstable;
    send_byte(8'h57);
    send_word(32'h0000_0010);
    send_word(32'hDEAD_BEEF);
    chk("wr_cyc_latency", 32'(wb_cyc_o), 32'd1);
    tick(); tick();
    chk("wr_txv_early", 32'(tx_valid), 32'd0);
    tick();
    chk("wr_txv_after_term", 32'(tx_valid), 32'd1);
    chk("wr_cyc_dropped", 32'(wb_cyc_o), 32'd0);
    recv_byte("wr_status", 8'h06, 0);
    chk("wr_cyc_cycles", 32'(cyc_cnt - c0), 32'd3);
    chk("wr_adr", cap_adr, 32'h0000_0010);
    chk("wr_dat", cap_dat, 32'hDEAD_BEEF);
    chk("wr_we",  32'(cap_we), 32'd1);
    chk("wr_sel", 32'(cap_sel), 32'hF);
    chk("wr_stable", 32'(unstable - u0), 32'd0);
    chk("wr_busy_end", 32'(busy), 32'd0);

    // read with tx back-pressure
    slv_mode = 0; slv_delay = 0; slv_data = 32'h1234_5678;
    hold_bad = 0;
    send_byte(8'h52);
    send_word(32'h7000_0004);
    recv_byte("rd_status", 8'h06, 5);
    recv_byte("rd_b0", 8'h12, 5);
    recv_byte("rd_b1", 8'h34, 5);
    recv_byte("rd_b2", 8'h56, 5);
    recv_byte("rd_b3", 8'h78, 5);
    chk("rd_adr", cap_adr, 32'h7000_0004);
    chk("rd_we", 32'(cap_we), 32'd0);
    chk("rd_hold", 32'(hold_bad), 32'd0);
    chk("rd_txv_end", 32'(tx_valid), 32'd0);
    chk("rd_busy_end", 32'(busy), 32'd0);

    // read terminated by err in first cycle
    slv_mode = 1; slv_delay = 0;
    c0 = cyc_cnt;
    send_byte(8'h52);
    send_word(32'h5000_0000);
    recv_byte("err_status", 8'h15, 0);
    chk("err_cyc_cycles", 32'(cyc_cnt - c0), 32'd1);
    chk("err_txv_end", 32'(tx_valid), 32'd0);
    chk("err_busy_end", 32'(busy), 32'd0);

    // silent slave -> timeout after 8 strobe cycles
    slv_mode = 2;
    s0 = stb_cnt;
    send_byte(8'h52);
    send_word(32'h4000_0000);
    recv_byte("tmo_status", 8'h14, 0);
    chk("tmo_stb_cycles", 32'(stb_cnt - s0), 32'd8);
    chk("tmo_txv_end", 32'(tx_valid), 32'd0);

    // next command after timeout runs normally
    slv_mode = 0; slv_delay = 1;
    send_byte(8'h57);
    send_word(32'h2000_0008);
    send_word(32'hCAFE_F00D);
    recv_byte("post_tmo_status", 8'h06, 0);
    chk("post_tmo_dat", cap_dat, 32'hCAFE_F00D);

    // ack and err together -> ack wins
    slv_mode = 3; slv_delay = 0;
    send_byte(8'h57);
    send_word(32'h3000_0000);
    send_word(32'h0000_0001);
    recv_byte("ackerr_status", 8'h06, 0);

    // unknown command
    c0 = cyc_cnt;
    send_byte(8'h41);
    recv_byte("bad_status", 8'h3F, 0);
    chk("bad_no_cyc", 32'(cyc_cnt - c0), 32'd0);
    chk("bad_busy_end", 32'(busy), 32'd0);

    // byte offered during BUS is stalled, then consumed afterwards
    slv_mode = 0; slv_delay = 3; slv_data = 32'hA5C3_0190;
    send_byte(8'h52);
    send_word(32'h1000_0000);
    rx_data  = 8'h41;
    rx_valid = 1'b1;
    chk("stall_rx_ready_bus", 32'(rx_ready), 32'd0);
    recv_byte("stall_status", 8'h06, 0);
    chk("stall_rx_ready_resp", 32'(rx_ready), 32'd0);
    recv_byte("stall_b0", 8'hA5, 0);
    recv_byte("stall_b1", 8'hC3, 0);
    recv_byte("stall_b2", 8'h01, 0);
    recv_byte("stall_b3", 8'h90, 0);
    chk("stall_rx_ready_idle", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
    recv_byte("stall_bad_status", 8'h3F, 0);

    // reset while the bus cycle is open
    slv_mode = 2;
    send_byte(8'h52);
    send_word(32'h6000_0000);
    chk("rst_mid_cyc_before", 32'(wb_cyc_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_mid_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_mid_txv", 32'(tx_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    slv_mode = 0; slv_delay = 0;
    send_byte(8'h57);
    send_word(32'h0000_0020);
    send_word(32'h0BAD_F00D);
    recv_byte("rst_after_status", 8'h06, 0);
    chk("rst_after_adr", cap_adr, 32'h0000_0020);
    chk("rst_after_dat", cap_dat, 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
